condicionador_botoes: RTL and testbench
=======================================

// Module: condicionador_botoes
// PURPOSE
//  Input-side partner of the LED-matrix controller: conditions the 8 raw puzzle push-buttons into
//  clean one-cycle toggle pulses on botoes_pulso, which feeds the controller's botoes port
//  directly, so one physical press produces exactly one toggle.
//  - Per button: 2-FF synchronizer, then a debounce FSM.
//  - Enable gate owned by the UC; saturating move counter for the score display.
// PARAMETERS
//  N_BOTOES         8      number of buttons
//  DEBOUNCE_CICLOS  50000  consecutive stable samples required (1 ms at 50 MHz); legal range >= 2
//  JOG_W            8      width of contador_jogadas
// PORTS
//  clk               in   1         system clock; only clock domain
//  rst               in   1         reset, synchronous, active-high
//  botoes_raw        in   N_BOTOES  asynchronous, bouncy button levels; 1 = pressed
//  habilita          in   1         1 = accept presses (UC drops it during level transitions)
//  limpar_jogadas    in   1         synchronous clear of contador_jogadas
//  botoes_pulso      out  N_BOTOES  one-cycle pulse per accepted press; to matriz botoes
//  botoes_estavel    out  N_BOTOES  debounced level per button
//  qualquer_pulso    out  1         OR of botoes_pulso, same cycle
//  contador_jogadas  out  JOG_W     accepted-press cycles, saturating
// BEHAVIOUR
//  Reset: all outputs 0, all FSMs in SOLTO, debounce counters 0, both sync FFs 0.
//   rst wins over every other input in the same cycle.
//  Sync: sync1 <= raw, sync2 <= sync1; the FSM uses sync2 only.
//  Debounce FSM states, per button; cnt width is $clog2(DEBOUNCE_CICLOS+1):
//   SOLTO        sync2=1 -> PRESS_PEND, cnt=1.
//   PRESS_PEND   sync2=1 -> cnt++; when cnt reaches DEBOUNCE_CICLOS, go to PRESSIONADO and
//                register pulse=habilita.
//                sync2=0 (bounce) -> SOLTO, cnt=0.
//   PRESSIONADO  sync2=0 -> SOLT_PEND, cnt=1.
//   SOLT_PEND    sync2=0 -> cnt++; when cnt reaches DEBOUNCE_CICLOS, go to SOLTO (no pulse).
//                sync2=1 -> PRESSIONADO, cnt=0.
//  botoes_estavel[i] = 1 in PRESSIONADO or SOLT_PEND; registered output.
//  Latency: raw first sampled high at edge N and held -> pulse high for exactly the one cycle
//   after edge N+1+DEBOUNCE_CICLOS. Release takes the same latency before estavel falls.
//  Held button: exactly one pulse, regardless of hold time. Re-arm requires a full debounced release.
//  habilita=0: FSMs keep tracking; a press completing now is dropped (no pulse, no count, not deferred).
//  Simultaneous presses: each button pulses independently in the same cycle.
//   contador_jogadas increments by 1 per cycle in which qualquer_pulso=1, not by popcount.
//  Counter: saturates at 2^JOG_W-1.
//   limpar_jogadas has priority over a same-cycle increment; result is 0.
//  Reset mid-debounce: any pending press or release is discarded.
//   A button still held when rst deasserts is treated as a new press and pulses after the full latency.
// STRUCTURE
//  puzzle_pkg: localparams for FSM encoding (SOLTO=2'd0, PRESS_PEND=2'd1, PRESSIONADO=2'd2,
//   SOLT_PEND=2'd3) and default DEBOUNCE_CICLOS.
//  Sub-module debounce_botao: one button (sync + FSM + cnt), ports clk, rst, raw, habilita, pulso,
//   estavel. Instantiated N_BOTOES times in a generate loop.
//  Top level holds only the OR reduction and the move counter.
// TESTING (DEBOUNCE_CICLOS=4, JOG_W=8)
//  1. Clean press: raw[0]=1 first sampled at edge 10 and held -> pulso[0] high only in the cycle
//     after edge 15; estavel[0]=1 from then on; contador=1.
//  2. Bounce: raw[3] toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during bounce, then exactly
//     one pulse DEBOUNCE_CICLOS+2 edges after the final rise; contador=1.
//  3. Hold 1000 cycles, release, press again -> two pulses total; estavel falls 6 edges after release.
//  4. habilita=0 during a press of raw[5] -> pulso stays 0, contador unchanged.
//     Press again with habilita=1 -> one pulse.
//  5. raw[1] and raw[6] rise on the same edge -> pulso=8'b0100_0010 in one cycle; contador +1;
//     preload to 255 and press -> stays 255; limpar_jogadas together with a pulse -> 0.
//  6. rst asserted for 1 cycle while raw[2] is in PRESS_PEND, raw held -> all outputs 0 after the rst
//     edge; one pulse after the full latency, counted from the first post-reset sample.

Source files
------------

// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button conditioner: debounce state encoding
// and the default debounce length.
package condicionador_botoes_pkg;

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    PRESS_PEND  = 2'd1,
    PRESSIONADO = 2'd2,
    SOLT_PEND   = 2'd3
  } estado_t;

  // 1 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;

endpackage

// File: rtl/condicionador_botoes_debounce_botao.sv
// One push-button: 2-FF synchronizer followed by a debounce FSM that emits
// a single registered pulse per debounced press.
module debounce_botao
  import condicionador_botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic habilita,
  output logic pulso,
  output logic estavel
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS);

  logic             sync1;
  logic             sync2;
  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      estado  <= SOLTO;
      cnt     <= '0;
      pulso   <= 1'b0;
      estavel <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulso <= 1'b0;
      case (estado)
        SOLTO: begin
          if (sync2) begin
            estado <= PRESS_PEND;
            cnt    <= CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!sync2) begin
            estado <= SOLTO;
            cnt    <= '0;
          end else if (cnt_inc == CNT_FIM) begin
            // A press completing while disabled is dropped, not deferred
            estado  <= PRESSIONADO;
            cnt     <= '0;
            pulso   <= habilita;
            estavel <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSIONADO: begin
          if (!sync2) begin
            estado <= SOLT_PEND;
            cnt    <= CNT_W'(1);
          end
        end
        SOLT_PEND: begin
          if (sync2) begin
            estado <= PRESSIONADO;
            cnt    <= '0;
          end else if (cnt_inc == CNT_FIM) begin
            estado  <= SOLTO;
            cnt     <= '0;
            estavel <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          estado <= SOLTO;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions the raw puzzle buttons into one-cycle toggle pulses and keeps
// a saturating count of cycles with at least one accepted press.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 8,
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned JOG_W           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                habilita,
  input  logic                limpar_jogadas,
  output logic [N_BOTOES-1:0] botoes_pulso,
  output logic [N_BOTOES-1:0] botoes_estavel,
  output logic                qualquer_pulso,
  output logic [JOG_W-1:0]    contador_jogadas
);

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
    debounce_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .raw     (botoes_raw[i]),
      .habilita(habilita),
      .pulso   (botoes_pulso[i]),
      .estavel (botoes_estavel[i])
    );
  end

  assign qualquer_pulso = |botoes_pulso;

  // One count per pulse cycle, regardless of how many buttons pulsed
  always_ff @(posedge clk) begin
    if (rst) begin
      contador_jogadas <= '0;
    end else if (limpar_jogadas) begin
      contador_jogadas <= '0;
    end else if (qualquer_pulso && (contador_jogadas != '1)) begin
      contador_jogadas <= contador_jogadas + 1'b1;
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a run-length model.
module tb_condicionador_botoes;

  localparam int unsigned D   = 4;
  localparam int unsigned NB  = 8;
  localparam int unsigned MAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] botoes_raw = '0;
  logic          habilita = 1'b1;
  logic          limpar_jogadas = 1'b0;
  logic [NB-1:0] botoes_pulso;
  logic [NB-1:0] botoes_estavel;
  logic          qualquer_pulso;
  logic [7:0]    contador_jogadas;

  condicionador_botoes #(
    .N_BOTOES(NB),
    .DEBOUNCE_CICLOS(D),
    .JOG_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .botoes_raw(botoes_raw),
    .habilita(habilita),
    .limpar_jogadas(limpar_jogadas),
    .botoes_pulso(botoes_pulso),
    .botoes_estavel(botoes_estavel),
    .qualquer_pulso(qualquer_pulso),
    .contador_jogadas(contador_jogadas)
  );

  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a level is accepted once D consecutive synchronized samples differ
  // from the current accepted level; an accepted rise pulses if enabled.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pulse = '0;
  int unsigned   m_run [NB];
  int unsigned   m_cnt = 0;
  bit            model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0; m_cnt = 0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      model_ok = 1'b1;
    end else begin
      if (limpar_jogadas) m_cnt = 0;
      else if (m_pulse != 0 && m_cnt < MAX) m_cnt = m_cnt + 1;
      for (int i = 0; i < NB; i++) begin
        m_pulse[i] = 1'b0;
        if (m_s2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_stable[i] = m_s2[i];
            m_run[i] = 0;
            if (m_stable[i] && habilita) m_pulse[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = botoes_raw;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_pulso",   32'(botoes_pulso),     32'(m_pulse));
      chk("model_estavel", 32'(botoes_estavel),   32'(m_stable));
      chk("model_any",     32'(qualquer_pulso),   32'(m_pulse != 0));
      chk("model_cont",    32'(contador_jogadas), m_cnt);
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic solta_tudo();
    botoes_raw = '0;
    cyc(10);
  endtask

  initial begin
    cyc(2);
    chk("reset_pulso", 32'(botoes_pulso), 32'h0);
    chk("reset_estavel", 32'(botoes_estavel), 32'h0);
    chk("reset_cont", 32'(contador_jogadas), 32'h0);
    rst = 1'b0;
    cyc(5);

    // 1: clean press
    botoes_raw[0] = 1'b1;
    cyc(5);
    chk("t1_pulse_early", 32'(botoes_pulso), 32'h0);
    cyc(1);
    chk("t1_pulse", 32'(botoes_pulso), 32'h01);
    chk("t1_any", 32'(qualquer_pulso), 32'h1);
    cyc(1);
    chk("t1_pulse_gone", 32'(botoes_pulso), 32'h0);
    chk("t1_estavel", 32'(botoes_estavel[0]), 32'h1);
    chk("t1_cont", 32'(contador_jogadas), 32'd1);
    solta_tudo();

    // 2: bounce then settle
    for (int k = 0; k < 4; k++) begin
      botoes_raw[3] = (k % 2 == 0);
      cyc(1);
    end
    botoes_raw[3] = 1'b1;
    cyc(5);
    chk("t2_pulse_early", 32'(botoes_pulso), 32'h0);
    cyc(1);
    chk("t2_pulse", 32'(botoes_pulso), 32'h08);
    cyc(1);
    chk("t2_cont", 32'(contador_jogadas), 32'd2);
    solta_tudo();

    // 3: long hold, release, press again
    botoes_raw[0] = 1'b1;
    cyc(1000);
    chk("t3_hold_cont", 32'(contador_jogadas), 32'd3);
    botoes_raw[0] = 1'b0;
    cyc(5);
    chk("t3_estavel_held", 32'(botoes_estavel[0]), 32'h1);
    cyc(1);
    chk("t3_estavel_fell", 32'(botoes_estavel[0]), 32'h0);
    cyc(4);
    botoes_raw[0] = 1'b1;
    cyc(10);
    chk("t3_cont", 32'(contador_jogadas), 32'd4);
    solta_tudo();

    // 4: disabled press dropped
    habilita = 1'b0;
    botoes_raw[5] = 1'b1;
    cyc(10);
    chk("t4_cont_dis", 32'(contador_jogadas), 32'd4);
    chk("t4_estavel", 32'(botoes_estavel[5]), 32'h1);
    habilita = 1'b1;
    solta_tudo();
    botoes_raw[5] = 1'b1;
    cyc(10);
    chk("t4_cont_en", 32'(contador_jogadas), 32'd5);
    solta_tudo();

    // 5: simultaneous presses, saturation, clear priority
    botoes_raw = 8'b0100_0010;
    cyc(6);
    chk("t5_pulse", 32'(botoes_pulso), 32'h42);
    cyc(1);
    chk("t5_cont", 32'(contador_jogadas), 32'd6);
    solta_tudo();
    for (int k = 0; k < 255; k++) begin
      botoes_raw[7] = 1'b1;
      cyc(8);
      botoes_raw[7] = 1'b0;
      cyc(7);
    end
    chk("t5_sat", 32'(contador_jogadas), 32'd255);
    botoes_raw[7] = 1'b1;
    cyc(8);
    chk("t5_sat_hold", 32'(contador_jogadas), 32'd255);
    solta_tudo();
    botoes_raw[0] = 1'b1;
    cyc(6);
    chk("t5_pulse_clr", 32'(botoes_pulso), 32'h01);
    limpar_jogadas = 1'b1;
    cyc(1);
    limpar_jogadas = 1'b0;
    chk("t5_clr", 32'(contador_jogadas), 32'd0);
    solta_tudo();

    // 6: reset mid-debounce with the button held
    botoes_raw[2] = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_rst_estavel", 32'(botoes_estavel), 32'h0);
    chk("t6_rst_pulse", 32'(botoes_pulso), 32'h0);
    cyc(5);
    chk("t6_pulse_early", 32'(botoes_pulso), 32'h0);
    cyc(1);
    chk("t6_pulse", 32'(botoes_pulso), 32'h04);
    solta_tudo();

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 15) == 0) botoes_raw[i] = ~botoes_raw[i];
      habilita       = ($urandom_range(0, 9) != 0);
      limpar_jogadas = ($urandom_range(0, 99) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    limpar_jogadas = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
